// File: rtl/bullet_pool.sv
// Multi-slot bullet engine: NUM_BUL bullets fired via req/ack, stepped on move_tick, drawn into VGA.
// Optional fire cooldown enabled by defining BULLET_POOL_COOLDOWN_EN.
module bullet_pool #(
    parameter int NUM_BUL = 4,
    parameter int COORD_W = 5,
    parameter int GRID_W  = 24,
    parameter int GRID_H  = 12,
    parameter int CELL    = 20,
    parameter int ORIGIN  = 80,
    parameter int HALF    = 3
`ifdef BULLET_POOL_COOLDOWN_EN
    ,
    parameter int COOLDOWN = 4
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         move_tick,
    input  logic                         fire_req,
    input  logic [1:0]                   fire_dir,
    input  logic [COORD_W-1:0]           fire_x,
    input  logic [COORD_W-1:0]           fire_y,
    output logic                         fire_ack,
    output logic                         pool_full,
    input  logic [NUM_BUL-1:0]           kill,
    output logic [NUM_BUL-1:0]           bul_active,
    output logic [NUM_BUL*COORD_W-1:0]   bul_x_flat,
    output logic [NUM_BUL*COORD_W-1:0]   bul_y_flat,
    output logic [NUM_BUL-1:0]           expire,
    input  logic [10:0]                  VGA_xpos,
    input  logic [10:0]                  VGA_ypos,
    output logic [11:0]                  VGA_data
);

    typedef enum logic {IDLE = 1'b0, FLY = 1'b1} slot_state_t;

    slot_state_t        state_q [NUM_BUL];
    slot_state_t        state_d [NUM_BUL];
    logic [COORD_W-1:0] x_q [NUM_BUL];
    logic [COORD_W-1:0] x_d [NUM_BUL];
    logic [COORD_W-1:0] y_q [NUM_BUL];
    logic [COORD_W-1:0] y_d [NUM_BUL];
    logic [1:0]         dir_q [NUM_BUL];
    logic [1:0]         dir_d [NUM_BUL];
    logic [NUM_BUL-1:0] expire_d;
    logic [NUM_BUL-1:0] load_sel;
    logic [NUM_BUL-1:0] at_edge;
    logic               any_idle;
    logic               accept;
    logic               cd_ok;
    logic               hit;
    logic [10:0]        cx [NUM_BUL];
    logic [10:0]        cy [NUM_BUL];

`ifdef BULLET_POOL_COOLDOWN_EN
    localparam int CD_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
    logic [CD_W-1:0] cd_q;

    // Accept reloads the counter; each enabled move tick drains it towards zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cd_q <= '0;
        end else if (accept) begin
            cd_q <= CD_W'(COOLDOWN);
        end else if (enable && move_tick && cd_q != '0) begin
            cd_q <= cd_q - 1'b1;
        end
    end

    assign cd_ok = (cd_q == '0);
`else
    assign cd_ok = 1'b1;
`endif

    // Lowest-index idle slot, judged on pre-cycle state so a slot killed now is not reused.
    always_comb begin
        load_sel = '0;
        any_idle = 1'b0;
        for (int i = 0; i < NUM_BUL; i++) begin
            if (state_q[i] == IDLE && !any_idle) begin
                load_sel[i] = 1'b1;
                any_idle    = 1'b1;
            end
        end
    end

    assign accept = enable && fire_req && !fire_ack && any_idle && cd_ok &&
                    (int'(fire_x) < GRID_W) && (int'(fire_y) < GRID_H);

    always_comb begin
        for (int i = 0; i < NUM_BUL; i++) begin
            unique case (dir_q[i])
                2'b00:   at_edge[i] = (y_q[i] == '0);
                2'b01:   at_edge[i] = (y_q[i] == COORD_W'(GRID_H - 1));
                2'b10:   at_edge[i] = (x_q[i] == '0);
                default: at_edge[i] = (x_q[i] == COORD_W'(GRID_W - 1));
            endcase
        end
    end

    // Per-slot next state: kill takes priority over movement.
    always_comb begin
        for (int i = 0; i < NUM_BUL; i++) begin
            state_d[i]  = state_q[i];
            x_d[i]      = x_q[i];
            y_d[i]      = y_q[i];
            dir_d[i]    = dir_q[i];
            expire_d[i] = 1'b0;
            if (enable) begin
                unique case (state_q[i])
                    IDLE: begin
                        if (accept && load_sel[i]) begin
                            state_d[i] = FLY;
                            x_d[i]     = fire_x;
                            y_d[i]     = fire_y;
                            dir_d[i]   = fire_dir;
                        end
                    end
                    FLY: begin
                        if (kill[i]) begin
                            state_d[i] = IDLE;
                            x_d[i]     = '1;
                            y_d[i]     = '1;
                        end else if (move_tick) begin
                            if (at_edge[i]) begin
                                state_d[i]  = IDLE;
                                x_d[i]      = '1;
                                y_d[i]      = '1;
                                expire_d[i] = 1'b1;
                            end else begin
                                unique case (dir_q[i])
                                    2'b00:   y_d[i] = y_q[i] - 1'b1;
                                    2'b01:   y_d[i] = y_q[i] + 1'b1;
                                    2'b10:   x_d[i] = x_q[i] - 1'b1;
                                    default: x_d[i] = x_q[i] + 1'b1;
                                endcase
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_BUL; i++) begin
            cx[i] = 11'(x_q[i]) * 11'(CELL) + 11'(ORIGIN);
            cy[i] = 11'(y_q[i]) * 11'(CELL) + 11'(ORIGIN);
            if (state_q[i] == FLY &&
                (cx[i] - 11'(HALF)) < VGA_xpos && VGA_xpos < (cx[i] + 11'(HALF)) &&
                (cy[i] - 11'(HALF)) < VGA_ypos && VGA_ypos < (cy[i] + 11'(HALF))) begin
                hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BUL; i++) begin
                state_q[i] <= IDLE;
                x_q[i]     <= '1;
                y_q[i]     <= '1;
                dir_q[i]   <= 2'b00;
            end
            fire_ack <= 1'b0;
            expire   <= '0;
            VGA_data <= 12'h000;
        end else begin
            for (int i = 0; i < NUM_BUL; i++) begin
                state_q[i] <= state_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
                dir_q[i]   <= dir_d[i];
            end
            fire_ack <= accept;
            expire   <= expire_d;
            VGA_data <= (enable && hit) ? 12'hFFF : 12'h000;
        end
    end

    for (genvar g = 0; g < NUM_BUL; g++) begin : g_out
        assign bul_active[g]                     = (state_q[g] == FLY);
        assign bul_x_flat[g*COORD_W +: COORD_W]  = x_q[g];
        assign bul_y_flat[g*COORD_W +: COORD_W]  = y_q[g];
    end

    assign pool_full = &bul_active;

endmodule

// File: tb/tb_bullet_pool.sv
// Self-checking bench for bullet_pool: directed scenarios plus randomized traffic against a behavioural model.
module tb_bullet_pool;
    localparam int NUM_BUL = 4;
    localparam int COORD_W = 5;
    localparam int GRID_W  = 24;
    localparam int GRID_H  = 12;
    localparam int CELL    = 20;
    localparam int ORIGIN  = 80;
    localparam int HALF    = 3;
    localparam int COOLDOWN = 4;

    logic clk = 1'b0;
    logic rst, enable, move_tick, fire_req;
    logic [1:0] fire_dir;
    logic [COORD_W-1:0] fire_x, fire_y;
    logic fire_ack, pool_full;
    logic [NUM_BUL-1:0] kill, bul_active, expire;
    logic [NUM_BUL*COORD_W-1:0] bul_x_flat, bul_y_flat;
    logic [10:0] VGA_xpos, VGA_ypos;
    logic [11:0] VGA_data;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: plain integers per slot.
    bit        m_act [NUM_BUL];
    int        m_x [NUM_BUL];
    int        m_y [NUM_BUL];
    int        m_dir [NUM_BUL];
    bit        m_ack;
    bit [NUM_BUL-1:0] m_exp;
    logic [11:0] m_vga;
    int        m_cd;

    always #5 clk = ~clk;

    bullet_pool #(
        .NUM_BUL(NUM_BUL), .COORD_W(COORD_W), .GRID_W(GRID_W), .GRID_H(GRID_H),
        .CELL(CELL), .ORIGIN(ORIGIN), .HALF(HALF)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .move_tick(move_tick),
        .fire_req(fire_req), .fire_dir(fire_dir), .fire_x(fire_x), .fire_y(fire_y),
        .fire_ack(fire_ack), .pool_full(pool_full), .kill(kill),
        .bul_active(bul_active), .bul_x_flat(bul_x_flat), .bul_y_flat(bul_y_flat),
        .expire(expire), .VGA_xpos(VGA_xpos), .VGA_ypos(VGA_ypos), .VGA_data(VGA_data)
    );

    function automatic int dut_x(int i);
        return int'(bul_x_flat[i*COORD_W +: COORD_W]);
    endfunction

    function automatic int dut_y(int i);
        return int'(bul_y_flat[i*COORD_W +: COORD_W]);
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    // Advance the model by one clock using the inputs as currently driven.
    task automatic model_step();
        bit hit, accept;
        int free, nx, ny;
        if (rst) begin
            for (int i = 0; i < NUM_BUL; i++) begin
                m_act[i] = 1'b0; m_x[i] = 31; m_y[i] = 31; m_dir[i] = 0;
            end
            m_ack = 1'b0; m_exp = '0; m_vga = 12'h000; m_cd = 0;
            return;
        end
        hit = 1'b0;
        for (int i = 0; i < NUM_BUL; i++)
            if (m_act[i] && iabs(int'(VGA_xpos) - (m_x[i]*CELL + ORIGIN)) < HALF &&
                iabs(int'(VGA_ypos) - (m_y[i]*CELL + ORIGIN)) < HALF)
                hit = 1'b1;
        m_vga = (enable && hit) ? 12'hFFF : 12'h000;
        if (!enable) begin
            m_ack = 1'b0; m_exp = '0;
            return;
        end
        free = -1;
        for (int i = 0; i < NUM_BUL; i++)
            if (!m_act[i] && free < 0) free = i;
        accept = fire_req && !m_ack && int'(fire_x) < GRID_W && int'(fire_y) < GRID_H && free >= 0;
`ifdef BULLET_POOL_COOLDOWN_EN
        accept = accept && (m_cd == 0);
`endif
        m_exp = '0;
        for (int i = 0; i < NUM_BUL; i++) begin
            if (!m_act[i]) continue;
            if (kill[i]) begin
                m_act[i] = 1'b0; m_x[i] = 31; m_y[i] = 31;
            end else if (move_tick) begin
                nx = m_x[i] + int'(m_dir[i] == 3) - int'(m_dir[i] == 2);
                ny = m_y[i] + int'(m_dir[i] == 1) - int'(m_dir[i] == 0);
                if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) begin
                    m_act[i] = 1'b0; m_x[i] = 31; m_y[i] = 31; m_exp[i] = 1'b1;
                end else begin
                    m_x[i] = nx; m_y[i] = ny;
                end
            end
        end
        if (accept) begin
            m_act[free] = 1'b1; m_x[free] = int'(fire_x); m_y[free] = int'(fire_y);
            m_dir[free] = int'(fire_dir);
        end
        m_ack = accept;
        if (accept) m_cd = COOLDOWN;
        else if (move_tick && m_cd > 0) m_cd = m_cd - 1;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic fire_once(input int x, input int y, input int dir, output bit acked);
        fire_x = COORD_W'(x); fire_y = COORD_W'(y); fire_dir = 2'(dir);
        fire_req = 1'b1;
        acked = 1'b0;
        for (int k = 0; k < 10 && !acked; k++) begin
            cycle();
            acked = fire_ack;
        end
        fire_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        cycle();
        checks++;
        if (bul_active !== 4'b0000 || pool_full !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_active: got %b/%b expected 0000/0", bul_active, pool_full);
        end
        checks++;
        if (bul_x_flat !== '1 || bul_y_flat !== '1) begin
            errors++;
            $display("[TB] FAIL reset_coords: got %h/%h expected all ones", bul_x_flat, bul_y_flat);
        end
        checks++;
        if (fire_ack !== 1'b0 || expire !== 4'b0000 || VGA_data !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: ack %b expire %b vga %h expected 0", fire_ack, expire, VGA_data);
        end
    endtask

    task automatic test_fire_move();
        do_reset();
        fire_x = 5'd5; fire_y = 5'd5; fire_dir = 2'b11; fire_req = 1'b1;
        cycle();
        checks++;
        if (fire_ack !== 1'b1 || bul_active !== 4'b0001 || dut_x(0) != 5 || dut_y(0) != 5) begin
            errors++;
            $display("[TB] FAIL fire_first: ack %b active %b pos (%0d,%0d) expected 1 0001 (5,5)",
                     fire_ack, bul_active, dut_x(0), dut_y(0));
        end
        fire_req = 1'b0;
        for (int t = 0; t < 3; t++) begin
            move_tick = 1'b1; cycle();
            move_tick = 1'b0; cycle();
        end
        checks++;
        if (dut_x(0) != 8 || dut_y(0) != 5 || bul_active !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL fire_move: pos (%0d,%0d) active %b expected (8,5) 0001",
                     dut_x(0), dut_y(0), bul_active);
        end
    endtask

    task automatic test_boundary();
        bit acked;
        do_reset();
        fire_once(0, 4, 2, acked);
        move_tick = 1'b1; cycle(); move_tick = 1'b0;
        checks++;
        if (!acked || expire !== 4'b0001 || bul_active !== 4'b0000 || dut_x(0) != 31 || dut_y(0) != 31) begin
            errors++;
            $display("[TB] FAIL boundary_exit: acked %b expire %b active %b pos (%0d,%0d) expected 1 0001 0000 (31,31)",
                     acked, expire, bul_active, dut_x(0), dut_y(0));
        end
        cycle();
        checks++;
        if (expire !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL boundary_pulse: expire %b expected 0000", expire);
        end
    endtask

    task automatic test_back_to_back();
        int acks, last, extra;
        do_reset();
        fire_x = 5'd2; fire_y = 5'd2; fire_dir = 2'b00; fire_req = 1'b1;
        acks = 0; last = -1;
        for (int c = 0; c < 20 && acks < 4; c++) begin
            cycle();
            if (fire_ack) begin
                if (acks > 0) begin
                    checks++;
                    if (c - last != 2) begin
                        errors++;
                        $display("[TB] FAIL b2b_spacing: got %0d clks expected 2", c - last);
                    end
                end
                last = c;
                acks++;
            end
        end
        checks++;
        if (acks != 4 || pool_full !== 1'b1 || bul_active !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL b2b_fill: acks %0d full %b active %b expected 4 1 1111", acks, pool_full, bul_active);
        end
        fire_x = 5'd7; fire_y = 5'd9;
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            cycle();
            if (fire_ack) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("[TB] FAIL b2b_full_refuse: got %0d acks expected 0", extra);
        end
        kill = 4'b0100; cycle(); kill = 4'b0000;
        checks++;
        if (fire_ack !== 1'b0 || bul_active !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL b2b_kill: ack %b active %b expected 0 1011", fire_ack, bul_active);
        end
        cycle();
        checks++;
        if (fire_ack !== 1'b1 || bul_active !== 4'b1111 || dut_x(2) != 7 || dut_y(2) != 9) begin
            errors++;
            $display("[TB] FAIL b2b_reuse: ack %b active %b slot2 (%0d,%0d) expected 1 1111 (7,9)",
                     fire_ack, bul_active, dut_x(2), dut_y(2));
        end
        fire_req = 1'b0;
        cycle();
    endtask

    task automatic test_kill_move();
        bit a0, a1;
        do_reset();
        fire_once(10, 6, 3, a0);
        for (int t = 0; t < 4; t++) begin
            move_tick = 1'b1; cycle();
            move_tick = 1'b0; cycle();
        end
        fire_once(3, 3, 0, a1);
        kill = 4'b0010; move_tick = 1'b1;
        cycle();
        kill = 4'b0000; move_tick = 1'b0;
        checks++;
        if (!a0 || !a1 || bul_active !== 4'b0001 || expire !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL kill_move_state: acks %b%b active %b expire %b expected 11 0001 0000",
                     a0, a1, bul_active, expire);
        end
        checks++;
        if (dut_x(1) != 31 || dut_y(1) != 31 || dut_x(0) != 15 || dut_y(0) != 6) begin
            errors++;
            $display("[TB] FAIL kill_move_pos: slot1 (%0d,%0d) slot0 (%0d,%0d) expected (31,31) (15,6)",
                     dut_x(1), dut_y(1), dut_x(0), dut_y(0));
        end
    endtask

    task automatic test_vga();
        bit acked;
        do_reset();
        fire_once(0, 0, 0, acked);
        VGA_xpos = 11'd80; VGA_ypos = 11'd80; cycle();
        checks++;
        if (!acked || VGA_data !== 12'hFFF) begin
            errors++;
            $display("[TB] FAIL vga_centre: acked %b got %h expected FFF", acked, VGA_data);
        end
        VGA_xpos = 11'd83; cycle();
        checks++;
        if (VGA_data !== 12'h000) begin
            errors++;
            $display("[TB] FAIL vga_edge_out: got %h expected 000", VGA_data);
        end
        VGA_xpos = 11'd82; VGA_ypos = 11'd78; cycle();
        checks++;
        if (VGA_data !== 12'hFFF) begin
            errors++;
            $display("[TB] FAIL vga_edge_in: got %h expected FFF", VGA_data);
        end
        enable = 1'b0; VGA_xpos = 11'd80; VGA_ypos = 11'd80; cycle();
        checks++;
        if (VGA_data !== 12'h000) begin
            errors++;
            $display("[TB] FAIL vga_disabled: got %h expected 000", VGA_data);
        end
        move_tick = 1'b1; fire_req = 1'b1; fire_x = 5'd4; fire_y = 5'd4;
        for (int t = 0; t < 3; t++) cycle();
        checks++;
        if (bul_active !== 4'b0001 || dut_x(0) != 0 || dut_y(0) != 0 || expire !== 4'b0000 || fire_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL freeze: active %b pos (%0d,%0d) expire %b ack %b expected 0001 (0,0) 0000 0",
                     bul_active, dut_x(0), dut_y(0), expire, fire_ack);
        end
        move_tick = 1'b0; fire_req = 1'b0; enable = 1'b1;
        cycle();
    endtask

`ifdef BULLET_POOL_COOLDOWN_EN
    task automatic test_cooldown();
        bit acked;
        do_reset();
        fire_once(5, 5, 3, acked);
        fire_x = 5'd6; fire_y = 5'd6; fire_dir = 2'b01; fire_req = 1'b1;
        for (int t = 0; t < 4; t++) begin
            move_tick = 1'b1; cycle(); move_tick = 1'b0;
            checks++;
            if (fire_ack !== 1'b0) begin
                errors++;
                $display("[TB] FAIL cooldown_tick%0d: ack %b expected 0", t, fire_ack);
            end
            cycle();
            checks++;
            if (fire_ack !== 1'(t == 3)) begin
                errors++;
                $display("[TB] FAIL cooldown_idle%0d: ack %b expected %b", t, fire_ack, t == 3);
            end
        end
        fire_req = 1'b0;
        cycle();
    endtask
`endif

    task automatic test_random();
        int hold, j, base;
        logic [NUM_BUL-1:0] ea;
        logic [NUM_BUL*COORD_W-1:0] ex, ey;
        do_reset();
        hold = 0;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(199) == 0);
            enable = ($urandom_range(7) != 0);
            move_tick = ($urandom_range(3) == 0);
            for (int i = 0; i < NUM_BUL; i++) kill[i] = ($urandom_range(11) == 0);
            if (fire_req && (fire_ack || hold > 4)) begin
                fire_req = 1'b0;
            end else if (!fire_req && $urandom_range(2) == 0) begin
                fire_req = 1'b1; hold = 0;
                fire_x = 5'($urandom_range(27)); fire_y = 5'($urandom_range(14));
                fire_dir = 2'($urandom_range(3));
            end
            if (fire_req) hold++;
            j = $urandom_range(NUM_BUL - 1);
            if (m_act[j] && $urandom_range(1) == 0) begin
                base = m_x[j]*CELL + ORIGIN; VGA_xpos = 11'(base + $urandom_range(8) - 4);
                base = m_y[j]*CELL + ORIGIN; VGA_ypos = 11'(base + $urandom_range(8) - 4);
            end else begin
                VGA_xpos = 11'($urandom_range(639)); VGA_ypos = 11'($urandom_range(479));
            end
            cycle();
            for (int i = 0; i < NUM_BUL; i++) begin
                ea[i] = m_act[i];
                ex[i*COORD_W +: COORD_W] = COORD_W'(m_x[i]);
                ey[i*COORD_W +: COORD_W] = COORD_W'(m_y[i]);
            end
            checks++;
            if (bul_active !== ea || pool_full !== (&ea)) begin
                errors++;
                $display("[TB] FAIL rnd_active c%0d: got %b/%b expected %b/%b", c, bul_active, pool_full, ea, &ea);
            end
            checks++;
            if (bul_x_flat !== ex || bul_y_flat !== ey) begin
                errors++;
                $display("[TB] FAIL rnd_coords c%0d: got %h/%h expected %h/%h", c, bul_x_flat, bul_y_flat, ex, ey);
            end
            checks++;
            if (fire_ack !== m_ack || expire !== m_exp) begin
                errors++;
                $display("[TB] FAIL rnd_pulses c%0d: ack %b expire %b expected %b %b", c, fire_ack, expire, m_ack, m_exp);
            end
            checks++;
            if (VGA_data !== m_vga) begin
                errors++;
                $display("[TB] FAIL rnd_vga c%0d: got %h expected %h", c, VGA_data, m_vga);
            end
        end
        rst = 1'b0; enable = 1'b1; move_tick = 1'b0; kill = '0; fire_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; move_tick = 1'b0; fire_req = 1'b0;
        fire_dir = 2'b00; fire_x = '0; fire_y = '0; kill = '0;
        VGA_xpos = '0; VGA_ypos = '0;
        @(negedge clk);
        test_reset();
        test_fire_move();
        test_boundary();
`ifndef BULLET_POOL_COOLDOWN_EN
        test_back_to_back();
`else
        test_cooldown();
`endif
        test_kill_move();
        test_vga();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
